// File: rtl/mux9_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
// Imported by rr_pick9 and mux9_rr_sched.
package mux9_pkg;

   localparam int SEL_W = 4;
   localparam logic [SEL_W-1:0] SEL_PARK = 4'hF;

   typedef enum logic [1:0] {
      ARB,
      CAPT,
      HOLD
   } state_t;

endpackage

// File: rtl/mux9_rr_sched_rr_pick9.sv
// Round-robin winner search: first set req bit after ptr, modulo NCH.
// Purely combinational; ptr is assumed to be a legal channel index.
module rr_pick9
   import mux9_pkg::*;
#(
   parameter int NCH = 9
) (
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   // Wrapped group (<= ptr) first, then the group above ptr overrides,
   // lowest index winning inside each group.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req[i] && (SEL_W'(i) <= ptr)) begin
            found = 1'b1;
            idx   = SEL_W'(i);
         end
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req[i] && (SEL_W'(i) > ptr)) begin
            found = 1'b1;
            idx   = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mux9_rr_sched.sv
// Round-robin scheduler driving an external 9:1 mux (ARB/CAPT/HOLD).
// Define MUX9_RR_SCHED_STATS_EN to add the saturating grant_cnt output.
module mux9_rr_sched
   import mux9_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NCH   = 9
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [NCH-1:0]   req,
   output logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] mux_out,
   output logic [NCH-1:0]   ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SEL_W-1:0] out_chan
`ifdef MUX9_RR_SCHED_STATS_EN
  ,output logic [15:0]      grant_cnt
`endif
);

   localparam logic [NCH-1:0] ONE = NCH'(1);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic             found;
   logic [SEL_W-1:0] idx;

   rr_pick9 #(
      .NCH (NCH)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (found),
      .idx   (idx)
   );

   // Scheduler FSM; every output is registered here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ARB;
         sel       <= SEL_PARK;
         ack       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= SEL_W'(NCH - 1);
      end else begin
         ack <= '0;
         case (state)
            ARB: begin
               if (found) begin
                  sel      <= idx;
                  out_chan <= idx;
                  ptr      <= idx;
                  state    <= CAPT;
               end else begin
                  sel <= SEL_PARK;
               end
            end
            CAPT: begin
               out_data  <= mux_out;
               ack       <= ONE << sel;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  sel       <= SEL_PARK;
                  state     <= ARB;
               end
            end
            default: begin
               sel   <= SEL_PARK;
               state <= ARB;
            end
         endcase
      end
   end

`ifdef MUX9_RR_SCHED_STATS_EN
   // Count CAPT entries, saturating at all-ones.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant_cnt <= '0;
      end else if (state == ARB && found && grant_cnt != 16'hFFFF) begin
         grant_cnt <= grant_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux9_rr_sched.sv
// Directed self-checking bench for mux9_rr_sched.
// Models the downstream mux as a fixed per-channel lookup table.
module tb_mux9_rr_sched;

   logic        clk = 1'b0;
   logic        resetn;
   logic [8:0]  req;
   logic [3:0]  sel;
   logic [15:0] mux_out;
   logic [8:0]  ack;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_chan;
`ifdef MUX9_RR_SCHED_STATS_EN
   logic [15:0] grant_cnt;
`endif

   logic [15:0] mdata [0:15];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux_out = mdata[sel];

   mux9_rr_sched #(
      .WIDTH (16),
      .NCH   (9)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .sel       (sel),
      .mux_out   (mux_out),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan)
`ifdef MUX9_RR_SCHED_STATS_EN
     ,.grant_cnt (grant_cnt)
`endif
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] ch;
      logic [8:0] one9;
      one9 = 9'h001;
      for (int i = 0; i < 16; i++) mdata[i] = 16'h1100 + 16'(i);
      mdata[2]  = 16'h000C;
      mdata[15] = 16'hFFFF;

      resetn = 1'b0;
      req = '0;
      out_ready = 1'b0;
      #12;
      check("rst_sel", 32'(sel), 32'hF);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_chan", 32'(out_chan), 32'h0);
`ifdef MUX9_RR_SCHED_STATS_EN
      check("rst_cnt", 32'(grant_cnt), 32'h0);
`endif
      tick();
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         out_ready = i[0];
         tick();
         check("idle_sel", 32'(sel), 32'hF);
         check("idle_valid", 32'(out_valid), 32'h0);
         check("idle_ack", 32'(ack), 32'h0);
      end

      out_ready = 1'b0;
      req = 9'h004;
      tick();
      check("one_sel", 32'(sel), 32'h2);
      check("one_chan", 32'(out_chan), 32'h2);
      check("one_v0", 32'(out_valid), 32'h0);
      check("one_ack0", 32'(ack), 32'h0);
      req = 9'h000;
      tick();
      check("one_valid", 32'(out_valid), 32'h1);
      check("one_data", 32'(out_data), 32'h000C);
      check("one_ack", 32'(ack), 32'h004);

      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 32'(out_valid), 32'h1);
         check("bp_data", 32'(out_data), 32'h000C);
         check("bp_sel", 32'(sel), 32'h2);
         check("bp_chan", 32'(out_chan), 32'h2);
         check("bp_ack", 32'(ack), 32'h0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_done_v", 32'(out_valid), 32'h0);
      check("bp_done_sel", 32'(sel), 32'hF);
      tick();
      check("bp_idle_v", 32'(out_valid), 32'h0);
`ifdef MUX9_RR_SCHED_STATS_EN
      check("cnt_one", 32'(grant_cnt), 32'h1);
`endif

      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      req = 9'h1FF;
      for (int g = 0; g < 10; g++) begin
         ch = 4'(g % 9);
         tick();
         check("fair_sel", 32'(sel), 32'(ch));
         check("fair_v0", 32'(out_valid), 32'h0);
         tick();
         check("fair_ack", 32'(ack), 32'(one9 << ch));
         check("fair_data", 32'(out_data), 32'(mdata[ch]));
         check("fair_chan", 32'(out_chan), 32'(ch));
         check("fair_v1", 32'(out_valid), 32'h1);
         tick();
         check("fair_v2", 32'(out_valid), 32'h0);
         check("fair_park", 32'(sel), 32'hF);
      end
`ifdef MUX9_RR_SCHED_STATS_EN
      check("cnt_fair", 32'(grant_cnt), 32'd10);
`endif

      req = 9'h100;
      tick();
      check("wrap_pre", 32'(sel), 32'h8);
      tick();
      tick();
      req = 9'h101;
      tick();
      check("wrap_ch0", 32'(sel), 32'h0);
      tick();
      check("wrap_ack0", 32'(ack), 32'h001);
      tick();
      tick();
      check("wrap_ch8", 32'(sel), 32'h8);
      tick();
      check("wrap_ack8", 32'(ack), 32'h100);
      tick();

      out_ready = 1'b0;
      req = 9'h010;
      tick();
      check("mh_sel", 32'(sel), 32'h4);
      tick();
      check("mh_valid", 32'(out_valid), 32'h1);
      tick();
      resetn = 1'b0;
      #1;
      check("mh_rst_v", 32'(out_valid), 32'h0);
      check("mh_rst_sel", 32'(sel), 32'hF);
      check("mh_rst_ack", 32'(ack), 32'h0);
`ifdef MUX9_RR_SCHED_STATS_EN
      check("mh_rst_cnt", 32'(grant_cnt), 32'h0);
`endif
      req = 9'h011;
      tick();
      resetn = 1'b1;
      tick();
      check("mh_next", 32'(sel), 32'h0);
      check("mh_next_v", 32'(out_valid), 32'h0);
      check("mh_next_ack", 32'(ack), 32'h0);
      tick();
      check("mh_next_data", 32'(out_data), 32'(mdata[0]));
      check("mh_next_ackc", 32'(ack), 32'h001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux9_rr_sched.md
MUX9_RR_SCHED -- requirements
Module: mux9_rr_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of mux_out and out_data.
REQ-002 SHALL have parameter NCH, default 9, channel count; legal values are 2..9 only.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port req, input, NCH, per-channel request; level-held until acked.
REQ-006 SHALL have port sel, output, 4, registered select that drives the downstream 9:1 mux.
REQ-007 SHALL have port mux_out, input, WIDTH, combinational return from that mux.
REQ-008 SHALL have port ack, output, NCH, one-hot, one-cycle pulse to the granted channel.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a captured word.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word.
REQ-011 SHALL have port out_data, output, WIDTH, registered captured word.
REQ-012 SHALL have port out_chan, output, 4, channel index of out_data.

Function
REQ-013 SHALL implement an FSM with states ARB, CAPT and HOLD.
REQ-014 ARB: if req is nonzero, SHALL pick the first set bit after ptr, modulo NCH, load sel and out_chan with its index, set ptr to that index, and go to CAPT.
REQ-015 ARB: if req is zero, SHALL stay in ARB with sel = 4'hF (park value, mux yields all-ones).
REQ-016 CAPT: SHALL set out_data = mux_out, pulse ack for the sel channel, set out_valid = 1, and go to HOLD.
REQ-017 HOLD: SHALL keep out_data, out_chan and sel stable while out_valid=1 and out_ready=0.
REQ-018 HOLD: on out_ready=1, SHALL clear out_valid, set sel = 4'hF, and go to ARB.
REQ-019 Throughput SHALL be at most one word per 3 cycles; the grant-to-out_valid latency is 2 cycles.
REQ-020 Priority SHALL be strict round-robin: a continuously requesting channel is granted within NCH grants.
REQ-021 The req bit of the current channel SHALL be ignored from CAPT until return to ARB; a deasserted req in CAPT still completes the capture.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 sel SHALL never take values NCH..14; it is either a channel index or 4'hF.

Reset
REQ-024 On resetn=0, asynchronously: state=ARB, sel=4'hF, ack=0, out_valid=0, out_data=0, out_chan=0, ptr=NCH-1 (first search starts at channel 0).
REQ-025 Reset mid-transaction SHALL discard the held word without any ack or valid glitch after release.

Configuration
REQ-026 Macro MUX9_RR_SCHED_STATS_EN defined: SHALL add output grant_cnt, 16 bits, counting CAPT entries, saturating at 16'hFFFF, reset to 0.
REQ-027 Macro undefined: SHALL omit the grant_cnt port and its counter entirely; behaviour is otherwise identical.

Structure
REQ-028 Package mux9_pkg SHALL hold the state enum (ARB, CAPT, HOLD), SEL_PARK = 4'hF and SEL_W = 4.
REQ-029 The round-robin winner search SHALL be the combinational sub-module rr_pick9, with inputs (req, ptr) and outputs (found, idx).

Verification
REQ-030 Reset and idle: resetn low then high, req=0 -> sel=4'hF, out_valid=0 and ack=0 for 10 cycles.
REQ-031 Single request: req=9'h004, mux returns 16'h000C -> sel=2 after 1 cycle, out_data=16'h000C and out_chan=2 with out_valid at cycle 2, ack=9'h004 for one cycle.
REQ-032 Fairness: req=9'h1FF held, out_ready=1 -> grant order 0,1,...,8,0 and a grant every 3 cycles.
REQ-033 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data, sel and out_chan stable; one word transfers when out_ready rises.
REQ-034 Wrap: ptr=8, req=9'h101 -> channel 0 granted, next grant channel 8.
REQ-035 Mid-HOLD reset: assert resetn=0 in HOLD -> out_valid drops immediately, next grant starts at channel 0; with MUX9_RR_SCHED_STATS_EN, grant_cnt=0.
